// File: rtl/register_file_sb_pkg.sv
// Shared constants for the scoreboarded register file.
package register_file_sb_pkg;

  localparam int              REG_ADDR_W = 5;
  localparam int              NUM_REGS   = 32;
  localparam int              DATA_W     = 32;
  localparam logic [4:0]      REG_ZERO   = 5'd0;

endpackage

// File: rtl/register_file_sb_dec.sv
// 5-to-32 enabled binary decoder: Y is one-hot on D when E is high, else all zero.
module binaryDecoder (
  input  logic [4:0]  D,
  input  logic        E,
  output logic [31:0] Y
);

  always_comb begin
    Y = '0;
    if (E) Y[D] = 1'b1;
  end

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with write-read bypass and a pending-write
// scoreboard used by the issue stage for hazard detection.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int DATA_W   = register_file_sb_pkg::DATA_W,
  parameter int NUM_REGS = register_file_sb_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic                  mark_en,
  input  logic [REG_ADDR_W-1:0] mark_addr,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic [31:0]           busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [31:0]       busy_q, busy_d;
  logic [31:0]       we_oh;
  logic [31:0]       mark_oh;
  logic              hit_a, hit_b;

  binaryDecoder u_wr_dec (
    .D (wr_addr),
    .E (wr_en),
    .Y (we_oh)
  );

  always_comb begin
    mark_oh = '0;
    if (mark_en) mark_oh[mark_addr] = 1'b1;
    // A mark on the same edge as the write-back belongs to a newer producer, so set wins.
    busy_d    = (busy_q & ~we_oh) | mark_oh;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_oh[i] && i != 0) regs_q[i] <= wr_data;
      end
      busy_q <= busy_d;
    end
  end

  // Bypass is gated by rst_n so outputs read zero throughout reset.
  assign hit_a = rst_n && wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != REG_ZERO);
  assign hit_b = rst_n && wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != REG_ZERO);

  assign rd_data_a = hit_a ? wr_data : regs_q[rd_addr_a];
  assign rd_data_b = hit_b ? wr_data : regs_q[rd_addr_b];

  assign busy_a   = busy_q[rd_addr_a] & ~(wr_en && (wr_addr == rd_addr_a));
  assign busy_b   = busy_q[rd_addr_b] & ~(wr_en && (wr_addr == rd_addr_b));
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb; the driver queues expected outputs and a
// monitor on the falling edge pops and compares them against the DUT.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        busy_a, busy_b;
  logic [31:0] busy_vec;

  typedef enum logic [2:0] {K_RDA, K_RDB, K_BSA, K_BSB, K_BVEC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_vec  (busy_vec)
  );

  task automatic expect_out(input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RDA:   act = rd_data_a;
          K_RDB:   act = rd_data_b;
          K_BSA:   act = {31'd0, busy_a};
          K_BSB:   act = {31'd0, busy_b};
          default: act = busy_vec;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    mark_en = 1'b1; mark_addr = 5'd5; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    step();
    step();
    expect_out(K_RDA, 32'h0, "rst_rd_a");
    expect_out(K_RDB, 32'h0, "rst_rd_b");
    expect_out(K_BSA, 32'h0, "rst_busy_a");
    expect_out(K_BSB, 32'h0, "rst_busy_b");
    expect_out(K_BVEC, 32'h0, "rst_busy_vec");
    step();
    wr_en = 1'b0; mark_en = 1'b0; rst_n = 1'b1;
    expect_out(K_RDA, 32'h0, "post_rst_r5");
    expect_out(K_BVEC, 32'h0, "post_rst_busy_vec");

    // Write r7, check bypass and stored value.
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr_a = 5'd7;
    expect_out(K_RDA, 32'h12345678, "wr7_bypass");
    step();
    wr_en = 1'b0;
    expect_out(K_RDA, 32'h12345678, "rd7_stored");

    // r0 is hardwired zero, no bypass either.
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    expect_out(K_RDA, 32'h0, "wr0_same_cycle");
    step();
    wr_en = 1'b0;
    expect_out(K_RDA, 32'h0, "rd0_a");
    expect_out(K_RDB, 32'h0, "rd0_b");

    // r3 = 0x11, mark pending, then bypassed write of 0x22.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
    step();
    wr_en = 1'b0; mark_en = 1'b1; mark_addr = 5'd3;
    step();
    mark_en = 1'b0; rd_addr_b = 5'd3;
    expect_out(K_RDB, 32'h11, "r3_stored");
    expect_out(K_BSB, 32'h1, "r3_busy");
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h22;
    expect_out(K_RDB, 32'h22, "r3_bypass");
    expect_out(K_BSB, 32'h0, "r3_bypass_not_busy");
    step();
    wr_en = 1'b0;
    expect_out(K_RDB, 32'h22, "r3_after");
    expect_out(K_BVEC, 32'h0, "r3_cleared");

    // Scoreboard on r9.
    mark_en = 1'b1; mark_addr = 5'd9;
    step();
    mark_en = 1'b0; rd_addr_a = 5'd9;
    expect_out(K_BVEC, 32'h0000_0200, "mark9_vec");
    expect_out(K_BSA, 32'h1, "mark9_busy_a");
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    expect_out(K_BSA, 32'h0, "wr9_busy_a_bypass");
    expect_out(K_RDA, 32'h99, "wr9_bypass");
    step();
    wr_en = 1'b0;
    expect_out(K_BVEC, 32'h0, "wr9_cleared");
    expect_out(K_BSA, 32'h0, "wr9_busy_a");

    // Collisions.
    mark_en = 1'b1; mark_addr = 5'd6;
    step();
    mark_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    step();
    mark_en = 1'b0; wr_en = 1'b0;
    expect_out(K_BVEC, 32'h0000_0050, "same_reg_set_wins");
    mark_en = 1'b1; mark_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    step();
    mark_en = 1'b0; wr_en = 1'b0;
    expect_out(K_BVEC, 32'h0000_0010, "diff_reg_set_clear");
    mark_en = 1'b1; mark_addr = 5'd0;
    step();
    mark_en = 1'b0;
    expect_out(K_BVEC, 32'h0000_0010, "mark0_ignored");
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h45;
    step();
    wr_en = 1'b0; rd_addr_a = 5'd6; rd_addr_b = 5'd6;
    expect_out(K_BVEC, 32'h0, "double_mark_one_clear");
    expect_out(K_RDA, 32'h66, "same_addr_rd_a");
    expect_out(K_RDB, 32'h66, "same_addr_rd_b");

    // Async reset between edges, held across an edge carrying a write and mark.
    mark_en = 1'b1; mark_addr = 5'd10;
    step();
    mark_en = 1'b0; rd_addr_a = 5'd7; rd_addr_b = 5'd10;
    expect_out(K_BVEC, 32'h0000_0400, "pre_rst_vec");
    expect_out(K_RDA, 32'h12345678, "pre_rst_r7");
    expect_out(K_BSB, 32'h1, "pre_rst_busy_b");
    step();
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hABCD;
    mark_en = 1'b1; mark_addr = 5'd8;
    expect_out(K_RDA, 32'h0, "async_rst_rd_a");
    expect_out(K_RDB, 32'h0, "async_rst_rd_b");
    expect_out(K_BSB, 32'h0, "async_rst_busy_b");
    expect_out(K_BVEC, 32'h0, "async_rst_vec");
    step();
    rst_n = 1'b1; wr_en = 1'b0; mark_en = 1'b0; rd_addr_a = 5'd8; rd_addr_b = 5'd7;
    expect_out(K_RDA, 32'h0, "rst_discard_r8");
    expect_out(K_RDB, 32'h0, "rst_cleared_r7");
    expect_out(K_BVEC, 32'h0, "rst_discard_mark");
    step();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    step();
    wr_en = 1'b0;
    expect_out(K_RDA, 32'h88, "post_rst_write");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count (fixed at 32, addressed by 5 bits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write-back strobe from the WB stage.
REQ-006 wr_addr  input  5  write-back destination register.
REQ-007 wr_data  input  DATA_W  write-back data.
REQ-008 rd_addr_a  input  5  read port A register address (rs).
REQ-009 rd_addr_b  input  5  read port B register address (rt).
REQ-010 rd_data_a  output  DATA_W  read port A data.
REQ-011 rd_data_b  output  DATA_W  read port B data.
REQ-012 mark_en  input  1  ID-stage strobe: an issued instruction will write mark_addr.
REQ-013 mark_addr  input  5  destination being marked pending.
REQ-014 busy_a  output  1  port A operand pending (hazard).
REQ-015 busy_b  output  1  port B operand pending (hazard).
REQ-016 busy_vec  output  32  full pending scoreboard, bit i = register i pending.

Function
REQ-017 Write enables SHALL be one-hot: bit i = wr_en & (wr_addr == i); register i loads wr_data on the rising edge when its bit is set.
REQ-018 Register 0 SHALL never be written; reads of address 0 SHALL return 0 regardless of wr_data.
REQ-019 Reads SHALL be combinational from stored contents (zero-cycle latency).
REQ-020 Write-read bypass: when wr_en=1, wr_addr=rd_addr_x and rd_addr_x!=0, rd_data_x SHALL equal wr_data in that same cycle.
REQ-021 Scoreboard bit i (i!=0) SHALL set on the rising edge when mark_en=1 and mark_addr=i.
REQ-022 Scoreboard bit i SHALL clear on the rising edge when wr_en=1 and wr_addr=i.
REQ-023 Simultaneous set and clear of the same register SHALL leave the bit set (new producer wins).
REQ-024 Set and clear of different registers in one cycle SHALL both take effect.
REQ-025 Scoreboard bit 0 SHALL be constant 0; mark of address 0 SHALL be ignored.
REQ-026 busy_x SHALL equal busy_vec[rd_addr_x] AND NOT (wr_en & wr_addr==rd_addr_x), so a bypassed operand is not reported busy.
REQ-027 Marking an already-pending register SHALL keep it pending (no counting); one write clears it.
REQ-028 Both read ports SHALL be independent; identical addresses SHALL return identical data and busy.

Reset
REQ-029 rst_n low SHALL immediately (no clock) clear all 32 registers to 0 and busy_vec to 0.
REQ-030 During reset rd_data_a/b SHALL be 0 and busy_a/b SHALL be 0, independent of wr_en or mark_en.
REQ-031 Reset asserted mid-operation SHALL discard any write or mark on the concurrent edge; first update occurs on the first rising edge after rst_n rises.

Structure
REQ-032 A shared package SHALL hold REG_ADDR_W=5, NUM_REGS=32, DATA_W=32 and REG_ZERO=5'd0.
REQ-033 The write-enable one-hot SHALL come from one instance of the team's 5-to-32 enabled decoder binaryDecoder (D=wr_addr, E=wr_en); register and scoreboard storage SHALL live in register_file_sb itself.
REQ-034 Reads SHALL be implemented as 32:1 multiplexers; no other sub-modules.

Verification
REQ-035 Reset: rst_n=0 with wr_en=1, wr_addr=5, wr_data=0xDEADBEEF -> after release, read addr 5 returns 0, busy_vec=0.
REQ-036 Write/read: write addr 7 = 0x12345678, next cycle rd_addr_a=7 -> rd_data_a=0x12345678; write addr 0 = 0xFFFFFFFF -> reads of 0 return 0.
REQ-037 Bypass: stored r3=0x11, same cycle wr_en=1, wr_addr=3, wr_data=0x22, rd_addr_b=3 -> rd_data_b=0x22 combinationally, busy_b=0.
REQ-038 Scoreboard: mark r9, next cycle busy_vec[9]=1 and rd_addr_a=9 -> busy_a=1; write r9 -> next cycle busy_vec[9]=0.
REQ-039 Collision: same edge mark_addr=4 and wr_addr=4 -> busy_vec[4]=1 afterwards; same edge mark 4, write 6 (pending) -> bit 4 set, bit 6 cleared.
REQ-040 Async reset mid-run: regs and busy populated, pulse rst_n low between edges -> outputs 0 before next clock edge.
